// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel type and test-grid helper.
// Defaults describe an 800x480 panel with a 32 MHz pixel clock.
package vga_pkg;

  localparam int DEF_HDISP  = 800;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;

  typedef logic [23:0] rgb888_t;

  localparam rgb888_t RGB_WHITE = 24'hFF_FFFF;
  localparam rgb888_t RGB_BLACK = 24'h00_0000;

  // The grid draws a white line on every 16th column and every 16th row.
  function automatic rgb888_t grid_pixel(input logic [3:0] h_low, input logic [3:0] v_low);
    return ((h_low == 4'd0) || (v_low == 4'd0)) ? RGB_WHITE : RGB_BLACK;
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N up counter with enable; wrap flags the enabled step from N-1 back to 0.
module vga_wrap_counter #(
  parameter int MODULUS = 928,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en && (count_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator with an upstream pixel stream, an internal
// grid test pattern and a sticky underflow flag for missed pixels.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  logic    pixel_clk,
  input  logic    pixel_rst_n,
  input  rgb888_t pix_dat,
  input  logic    pix_valid,
  output logic    pix_ready,
  input  logic    test_mode,
  input  logic    clear_underflow,
  output logic    video_hs,
  output logic    video_vs,
  output logic    video_de,
  output rgb888_t video_rgb,
  output logic    frame_start,
  output logic    underflow
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_DISP     = HW'(HDISP);
  localparam logic [HW-1:0] H_HS_START = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_HS_END   = HW'(HDISP + HFP + HPULSE);
  localparam logic [VW-1:0] V_DISP     = VW'(VDISP);
  localparam logic [VW-1:0] V_VS_START = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_VS_END   = VW'(VDISP + VFP + VPULSE);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_end;
  logic          active;

  vga_wrap_counter #(
    .MODULUS (HTOTAL),
    .WIDTH   (HW)
  ) u_hcount (
    .clk   (pixel_clk),
    .rst_n (pixel_rst_n),
    .en    (1'b1),
    .count (hcount),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(
    .MODULUS (VTOTAL),
    .WIDTH   (VW)
  ) u_vcount (
    .clk   (pixel_clk),
    .rst_n (pixel_rst_n),
    .en    (h_wrap),
    .count (vcount),
    .wrap  (v_wrap)
  );

  // The vertical counter only wraps on a horizontal wrap, so this marks the last pixel of a frame.
  assign frame_end = v_wrap;
  assign active    = (hcount < H_DISP) && (vcount < V_DISP);

  logic    hs_d, hs_q;
  logic    vs_d, vs_q;
  logic    de_d, de_q;
  logic    frame_start_d, frame_start_q;
  logic    underflow_d, underflow_q;
  logic    test_eff_d, test_eff_q;
  rgb888_t rgb_d, rgb_q;

  // Gated by reset so the block never advertises readiness while held in reset.
  assign pix_ready = pixel_rst_n && active && !test_eff_q;

  always_comb begin
    hs_d          = !((hcount >= H_HS_START) && (hcount < H_HS_END));
    vs_d          = !((vcount >= V_VS_START) && (vcount < V_VS_END));
    de_d          = active;
    frame_start_d = (hcount == '0) && (vcount == '0);
    rgb_d         = RGB_BLACK;
    underflow_d   = underflow_q;
    test_eff_d    = test_eff_q;

    if (active) begin
      if (test_eff_q) begin
        rgb_d = grid_pixel(hcount[3:0], vcount[3:0]);
      end else if (pix_valid) begin
        rgb_d = pix_dat;
      end
    end

    // A fresh miss takes priority over a clear arriving in the same cycle.
    if (clear_underflow) begin
      underflow_d = 1'b0;
    end
    if (pix_ready && !pix_valid) begin
      underflow_d = 1'b1;
    end

    if (frame_end) begin
      test_eff_d = test_mode;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= RGB_BLACK;
      underflow_q   <= 1'b0;
      test_eff_q    <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      underflow_q   <= underflow_d;
      test_eff_q    <= test_eff_d;
    end
  end

  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing.sv
// Randomized bench for vga_timing on a shrunken raster, checked against a
// position-based reference model (frame offset -> x,y via div/mod).
module tb_vga_timing;

  localparam int HDISP  = 40;
  localparam int HFP    = 4;
  localparam int HPULSE = 6;
  localparam int HBP    = 5;
  localparam int VDISP  = 20;
  localparam int VFP    = 3;
  localparam int VPULSE = 2;
  localparam int VBP    = 4;
  localparam int HT     = HDISP + HFP + HPULSE + HBP;
  localparam int VT     = VDISP + VFP + VPULSE + VBP;
  localparam int FRAME  = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b1;
  logic [23:0] pix_dat = 24'h0;
  logic        pix_valid = 1'b0;
  logic        test_mode = 1'b0;
  logic        clear_underflow = 1'b0;
  logic        pix_ready;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [23:0] video_rgb;
  logic        frame_start;
  logic        underflow;

  vga_timing #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk       (pixel_clk),
    .pixel_rst_n     (pixel_rst_n),
    .pix_dat         (pix_dat),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .test_mode       (test_mode),
    .clear_underflow (clear_underflow),
    .video_hs        (video_hs),
    .video_vs        (video_vs),
    .video_de        (video_de),
    .video_rgb       (video_rgb),
    .frame_start     (frame_start),
    .underflow       (underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checkCount = 0;
  int passCount = 0;
  int cycleNum = 0;

  // Reference model state: frame offset of the pixel the next edge processes.
  int pos = 0;
  bit modelEff = 0;
  bit modelUf = 0;
  bit expHs = 1, expVs = 1, expDe = 0, expFs = 0, expUf = 0;
  logic [23:0] expRgb = 24'h0;
  logic [23:0] seqData = 24'h0;
  int lastX = -1, lastY = -1;
  bit lastEff = 0;
  int lastFsCycle = -1;
  int releaseCycle = 0;
  int hsLowRun = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  function automatic logic [23:0] gridColour(input int x, input int y);
    return ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
  endfunction

  // mode 0: pix_valid held high with an incrementing data count; mode 1: random.
  task automatic applyStimulus(input bit rstLevel, input int mode, input bit tmLevel);
    int x, y;
    bit active, expReady, pv, clr;
    logic [23:0] pd;

    @(negedge pixel_clk);
    cycleNum++;

    checkOutput("video_hs", 32'(video_hs), 32'(expHs));
    checkOutput("video_vs", 32'(video_vs), 32'(expVs));
    checkOutput("video_de", 32'(video_de), 32'(expDe));
    checkOutput("video_rgb", 32'(video_rgb), 32'(expRgb));
    checkOutput("frame_start", 32'(frame_start), 32'(expFs));
    checkOutput("underflow", 32'(underflow), 32'(expUf));

    if (pixel_rst_n) begin
      if (frame_start) begin
        if (lastFsCycle < 0) checkOutput("fs_first_latency", cycleNum - releaseCycle, 1);
        else checkOutput("fs_period", cycleNum - lastFsCycle, FRAME);
        lastFsCycle = cycleNum;
      end
      if (!video_hs) begin
        hsLowRun++;
      end else begin
        if (hsLowRun > 0) checkOutput("hs_width", hsLowRun, HPULSE);
        hsLowRun = 0;
      end
      if (lastEff && lastY == 5 && lastX == 16) checkOutput("grid_16_5", 32'(video_rgb), 32'hFFFFFF);
      if (lastEff && lastY == 5 && lastX == 17) checkOutput("grid_17_5", 32'(video_rgb), 32'h000000);
    end else begin
      lastFsCycle = -1;
      hsLowRun = 0;
    end

    if (!pixel_rst_n && rstLevel) releaseCycle = cycleNum;

    x = pos % HT;
    y = pos / HT;
    active = (x < HDISP) && (y < VDISP);
    pv = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
    pd = (mode == 0) ? seqData : 24'($urandom);
    clr = ($urandom_range(0, 15) == 0);

    pixel_rst_n = rstLevel;
    pix_valid = pv;
    pix_dat = pd;
    clear_underflow = clr;
    test_mode = tmLevel;
    #1;

    if (!rstLevel) begin
      checkOutput("pix_ready_rst", 32'(pix_ready), 32'd0);
      checkOutput("de_rst_async", 32'(video_de), 32'd0);
      checkOutput("hs_rst_async", 32'(video_hs), 32'd1);
      pos = 0;
      modelEff = 0;
      modelUf = 0;
      expHs = 1; expVs = 1; expDe = 0; expFs = 0; expUf = 0;
      expRgb = 24'h0;
      lastX = -1; lastY = -1; lastEff = 0;
    end else begin
      expReady = active && !modelEff;
      checkOutput("pix_ready", 32'(pix_ready), 32'(expReady));
      expDe = active;
      expHs = !((x >= HDISP + HFP) && (x < HDISP + HFP + HPULSE));
      expVs = !((y >= VDISP + VFP) && (y < VDISP + VFP + VPULSE));
      expFs = (pos == 0);
      if (!active) expRgb = 24'h0;
      else if (modelEff) expRgb = gridColour(x, y);
      else expRgb = pv ? pd : 24'h0;
      if (expReady && !pv) modelUf = 1;
      else if (clr) modelUf = 0;
      expUf = modelUf;
      if (mode == 0 && expReady && pv) seqData = seqData + 24'd1;
      lastX = x; lastY = y; lastEff = modelEff;
      if (pos == FRAME - 1) modelEff = tmLevel;
      pos = (pos + 1) % FRAME;
    end
  endtask

  initial begin
    #2 pixel_rst_n = 1'b0;

    repeat (5) applyStimulus(1'b0, 1, 1'b0);

    // Streaming with pix_valid held high: no gaps, no repeats, no underflow.
    for (int i = 0; i < 2 * FRAME + 10; i++) applyStimulus(1'b1, 0, 1'b0);

    // Random traffic; test_mode rises and later falls in the middle of frames.
    for (int i = 0; i < 3 * FRAME; i++)
      applyStimulus(1'b1, 1, (i >= FRAME / 2) && (i < 2 * FRAME + FRAME / 2));

    // Abort a frame with a reset pulse part-way down the raster.
    for (int i = 0; i < FRAME && pos != 10 * HT + 7; i++) applyStimulus(1'b1, 1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1, 1'b0);

    for (int i = 0; i < 2 * FRAME + 5; i++) applyStimulus(1'b1, 1, 1'($urandom_range(0, 1)));

    applyStimulus(1'b1, 1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
